// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack memory controller.
// The optional bounds checking is selected by STACK_CTRL_BOUNDS_CHECK_EN.
package stack_ctrl_pkg;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_POKE = 2'd3;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_RANGE     = 2'd3;

  localparam logic [15:0] ADDR_RANGE_MASK = 16'hC000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // The data memory only decodes 14 address bits.
  function automatic logic addr_out_of_range(input logic [15:0] addr);
    return (addr & ADDR_RANGE_MASK) != 16'h0000;
  endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// Next-pointer computation and overflow/underflow/range checks for one request.
// Checks are reported only when STACK_CTRL_BOUNDS_CHECK_EN is defined.
module stack_bounds_check
  import stack_ctrl_pkg::*;
#(
  parameter logic [15:0] STACK_BASE  = 16'h0000,
  parameter logic [15:0] STACK_LIMIT = 16'h3FFF
) (
  input  logic [15:0] sp,
  input  logic [1:0]  op,
  output logic [15:0] sp_next,
  output logic [1:0]  err_code
);

`ifdef STACK_CTRL_BOUNDS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [1:0] raw_err_s;

  // Pointer after the operation and the first rule it would break.
  always_comb begin
    sp_next   = sp;
    raw_err_s = ERR_NONE;
    case (op)
      OP_PUSH: begin
        sp_next = sp + 16'd1;
        if (sp == STACK_LIMIT) begin
          raw_err_s = ERR_OVERFLOW;
        end else if (addr_out_of_range(sp_next)) begin
          raw_err_s = ERR_RANGE;
        end else begin
          raw_err_s = ERR_NONE;
        end
      end
      OP_POP: begin
        sp_next = sp - 16'd1;
        if (sp == STACK_BASE) begin
          raw_err_s = ERR_UNDERFLOW;
        end else if (addr_out_of_range(sp_next)) begin
          raw_err_s = ERR_RANGE;
        end else begin
          raw_err_s = ERR_NONE;
        end
      end
      OP_POKE: begin
        sp_next = sp;
        if (sp == STACK_BASE) begin
          raw_err_s = ERR_UNDERFLOW;
        end else if (addr_out_of_range(sp_next)) begin
          raw_err_s = ERR_RANGE;
        end else begin
          raw_err_s = ERR_NONE;
        end
      end
      default: begin
        sp_next   = sp;
        raw_err_s = ERR_NONE;
      end
    endcase
  end

  assign err_code = CHECK_EN ? raw_err_s : ERR_NONE;

endmodule

// File: rtl/stack_mem_ctrl.sv
// Stack-pointer controller: turns PUSH/POP/POKE into data-memory write sequences.
// Bounds checking and the FAULT state are active only with STACK_CTRL_BOUNDS_CHECK_EN.
module stack_mem_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [15:0] STACK_BASE  = 16'h0000,
  parameter logic [15:0] STACK_LIMIT = 16'h3FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [15:0] op_data,
  input  logic        err_clear,
  output logic        ready,
  output logic [15:0] tos,
  output logic [15:0] nos,
  output logic [15:0] depth,
  output logic [1:0]  err_code,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_wea,
  input  logic [15:0] mem_douta,
  input  logic [15:0] mem_doutb
);

  state_e      state_r, state_nx_s;
  logic [15:0] sp_r, sp_nx_s;
  logic [15:0] din_r, din_nx_s;
  logic [1:0]  err_r, err_nx_s;
  logic        wea_r;
  logic        ready_r;
  logic [15:0] depth_r;
  logic [15:0] chk_sp_s;
  logic [1:0]  chk_err_s;

  stack_bounds_check #(
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bounds (
    .sp       (sp_r),
    .op       (op),
    .sp_next  (chk_sp_s),
    .err_code (chk_err_s)
  );

  // Next state, pointer, write data and error code.
  always_comb begin
    state_nx_s = state_r;
    sp_nx_s    = sp_r;
    din_nx_s   = din_r;
    err_nx_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (op_valid && (op != OP_NOP)) begin
          if (chk_err_s != ERR_NONE) begin
            // A failing request is dropped whole: no pointer move, no write.
            state_nx_s = ST_FAULT;
            err_nx_s   = chk_err_s;
          end else if (op == OP_POP) begin
            sp_nx_s    = chk_sp_s;
            state_nx_s = ST_SETTLE;
          end else begin
            sp_nx_s    = chk_sp_s;
            din_nx_s   = op_data;
            state_nx_s = ST_WRITE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WRITE:  state_nx_s = ST_SETTLE;
      ST_SETTLE: state_nx_s = ST_IDLE;
      ST_FAULT: begin
        if (err_clear) begin
          state_nx_s = ST_IDLE;
          err_nx_s   = ERR_NONE;
        end else begin
          state_nx_s = ST_FAULT;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next-state decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      sp_r    <= STACK_BASE;
      din_r   <= 16'h0000;
      err_r   <= ERR_NONE;
      wea_r   <= 1'b0;
      ready_r <= 1'b1;
      depth_r <= 16'h0000;
    end else begin
      state_r <= state_nx_s;
      sp_r    <= sp_nx_s;
      din_r   <= din_nx_s;
      err_r   <= err_nx_s;
      wea_r   <= (state_nx_s == ST_WRITE);
      ready_r <= (state_nx_s == ST_IDLE);
      depth_r <= sp_nx_s - STACK_BASE;
    end
  end

  assign ready    = ready_r;
  assign depth    = depth_r;
  assign err_code = err_r;
  assign mem_addr = sp_r;
  assign mem_din  = din_r;
  assign mem_wea  = wea_r;
  assign tos      = mem_douta;
  assign nos      = mem_doutb;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl; expectations follow STACK_CTRL_BOUNDS_CHECK_EN.
module tb_stack_mem_ctrl;
  import stack_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance (default limits)
  logic        op_valid = 1'b0, err_clear = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] op_data = 16'h0000;
  logic        ready, mem_wea;
  logic [15:0] tos, nos, depth, mem_addr, mem_din, mem_douta, mem_doutb;
  logic [1:0]  err_code;
  logic [15:0] mem [0:16383] = '{default: 16'h0000};

  // small-limit instance
  logic        op_valid2 = 1'b0, err_clear2 = 1'b0;
  logic [1:0]  op2 = 2'd0;
  logic [15:0] op_data2 = 16'h0000;
  logic        ready2, mem_wea2;
  logic [15:0] tos2, nos2, depth2, mem_addr2, mem_din2, mem_douta2, mem_doutb2;
  logic [1:0]  err_code2;
  logic [15:0] mem2 [0:15] = '{default: 16'h0000};

  int n_checks = 0;
  int n_pass = 0;

  stack_mem_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_data(op_data),
    .err_clear(err_clear), .ready(ready), .tos(tos), .nos(nos), .depth(depth),
    .err_code(err_code), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea),
    .mem_douta(mem_douta), .mem_doutb(mem_doutb)
  );

  stack_mem_ctrl #(.STACK_LIMIT(16'd2)) dut2 (
    .clk(clk), .reset(reset), .op_valid(op_valid2), .op(op2), .op_data(op_data2),
    .err_clear(err_clear2), .ready(ready2), .tos(tos2), .nos(nos2), .depth(depth2),
    .err_code(err_code2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_wea(mem_wea2),
    .mem_douta(mem_douta2), .mem_doutb(mem_doutb2)
  );

  // data memories: write on clock edge, asynchronous dual read at addr and addr-1
  always @(posedge clk) if (mem_wea) mem[mem_addr[13:0]] <= mem_din;
  always @(posedge clk) if (mem_wea2) mem2[mem_addr2[3:0]] <= mem_din2;
  assign mem_douta  = mem[mem_addr[13:0]];
  assign mem_doutb  = mem[mem_addr[13:0] - 14'd1];
  assign mem_douta2 = mem2[mem_addr2[3:0]];
  assign mem_doutb2 = mem2[mem_addr2[3:0] - 4'd1];

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0; err_clear = 1'b0; op_valid2 = 1'b0; err_clear2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // present one request for one cycle; optionally wait (bounded) for ready
  task automatic issue(input logic [1:0] o, input logic [15:0] d, input bit wait_rdy,
                       output int low, output int wcyc);
    @(negedge clk);
    op_valid = 1'b1; op = o; op_data = d;
    @(negedge clk);
    op_valid = 1'b0; op = OP_NOP;
    low = 0; wcyc = 0;
    while (wait_rdy && !ready && low < 8) begin
      if (mem_wea) wcyc++;
      low++;
      @(negedge clk);
    end
  endtask

  task automatic issue2(input logic [1:0] o, input logic [15:0] d, input bit wait_rdy,
                        output int low);
    @(negedge clk);
    op_valid2 = 1'b1; op2 = o; op_data2 = d;
    @(negedge clk);
    op_valid2 = 1'b0; op2 = OP_NOP;
    low = 0;
    while (wait_rdy && !ready2 && low < 8) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL reset_addr got %h want 0000", mem_addr); else n_pass++;
    n_checks++; if (mem_wea !== 1'b0) $display("FAIL reset_wea got %b want 0", mem_wea); else n_pass++;
    n_checks++; if (mem_din !== 16'h0000) $display("FAIL reset_din got %h want 0000", mem_din); else n_pass++;
    n_checks++; if (depth !== 16'h0000) $display("FAIL reset_depth got %h want 0000", depth); else n_pass++;
    n_checks++; if (err_code !== 2'd0) $display("FAIL reset_err got %0d want 0", err_code); else n_pass++;
  endtask

  task automatic test_push;
    int low, wc;
    apply_reset();
    issue(OP_PUSH, 16'd100, 1'b1, low, wc);
    n_checks++; if (low !== 2) $display("FAIL push_ready_low got %0d want 2", low); else n_pass++;
    n_checks++; if (mem_addr !== 16'd1) $display("FAIL push_addr got %0d want 1", mem_addr); else n_pass++;
    n_checks++; if (tos !== 16'd100) $display("FAIL push_tos got %0d want 100", tos); else n_pass++;
    n_checks++; if (nos !== 16'd0) $display("FAIL push_nos got %0d want 0", nos); else n_pass++;
    n_checks++; if (depth !== 16'd1) $display("FAIL push_depth got %0d want 1", depth); else n_pass++;
  endtask

  task automatic test_pop;
    int low, wc;
    apply_reset();
    issue(OP_PUSH, 16'd100, 1'b1, low, wc);
    issue(OP_PUSH, 16'd1000, 1'b1, low, wc);
    issue(OP_POP, 16'd0, 1'b1, low, wc);
    n_checks++; if (low !== 1) $display("FAIL pop_ready_low got %0d want 1", low); else n_pass++;
    n_checks++; if (tos !== 16'd100) $display("FAIL pop_tos got %0d want 100", tos); else n_pass++;
    n_checks++; if (depth !== 16'd1) $display("FAIL pop_depth got %0d want 1", depth); else n_pass++;
  endtask

  task automatic test_poke;
    int low, wc;
    apply_reset();
    issue(OP_PUSH, 16'd100, 1'b1, low, wc);
    issue(OP_POKE, 16'd10000, 1'b1, low, wc);
    n_checks++; if (wc !== 1) $display("FAIL poke_wea_cycles got %0d want 1", wc); else n_pass++;
    n_checks++; if (low !== 2) $display("FAIL poke_ready_low got %0d want 2", low); else n_pass++;
    n_checks++; if (tos !== 16'd10000) $display("FAIL poke_tos got %0d want 10000", tos); else n_pass++;
    n_checks++; if (nos !== 16'd0) $display("FAIL poke_nos got %0d want 0", nos); else n_pass++;
    n_checks++; if (depth !== 16'd1) $display("FAIL poke_depth got %0d want 1", depth); else n_pass++;
  endtask

  task automatic test_clear_idle;
    apply_reset();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    n_checks++; if (ready !== 1'b1) $display("FAIL clear_idle_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (depth !== 16'd0) $display("FAIL clear_idle_depth got %0d want 0", depth); else n_pass++;
  endtask

  task automatic test_underflow;
    int low, wc;
    apply_reset();
`ifdef STACK_CTRL_BOUNDS_CHECK_EN
    issue(OP_POP, 16'd0, 1'b0, low, wc);
    n_checks++; if (err_code !== 2'd2) $display("FAIL uflow_err got %0d want 2", err_code); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL uflow_ready got %b want 0", ready); else n_pass++;
    n_checks++; if (mem_addr !== 16'd0) $display("FAIL uflow_sp got %h want 0000", mem_addr); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (err_code !== 2'd2) $display("FAIL uflow_sticky got %0d want 2", err_code); else n_pass++;
    @(negedge clk);
    err_clear = 1'b1; op_valid = 1'b1; op = OP_PUSH; op_data = 16'd77;
    @(negedge clk);
    err_clear = 1'b0; op_valid = 1'b0; op = OP_NOP;
    n_checks++; if (ready !== 1'b1) $display("FAIL clear_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (err_code !== 2'd0) $display("FAIL clear_err got %0d want 0", err_code); else n_pass++;
    @(negedge clk);
    n_checks++; if (depth !== 16'd0) $display("FAIL clear_op_dropped got depth %0d want 0", depth); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL clear_op_ready got %b want 1", ready); else n_pass++;
`else
    issue(OP_POP, 16'd0, 1'b1, low, wc);
    n_checks++; if (low !== 1) $display("FAIL wrap_ready_low got %0d want 1", low); else n_pass++;
    n_checks++; if (depth !== 16'hFFFF) $display("FAIL wrap_depth got %h want ffff", depth); else n_pass++;
    n_checks++; if (mem_addr !== 16'hFFFF) $display("FAIL wrap_addr got %h want ffff", mem_addr); else n_pass++;
    n_checks++; if (err_code !== 2'd0) $display("FAIL wrap_err got %0d want 0", err_code); else n_pass++;
`endif
  endtask

  task automatic test_overflow;
    int low;
    apply_reset();
    issue2(OP_PUSH, 16'd11, 1'b1, low);
    issue2(OP_PUSH, 16'd22, 1'b1, low);
`ifdef STACK_CTRL_BOUNDS_CHECK_EN
    issue2(OP_PUSH, 16'd33, 1'b0, low);
    n_checks++; if (err_code2 !== 2'd1) $display("FAIL oflow_err got %0d want 1", err_code2); else n_pass++;
    n_checks++; if (mem_wea2 !== 1'b0) $display("FAIL oflow_wea got %b want 0", mem_wea2); else n_pass++;
    n_checks++; if (depth2 !== 16'd2) $display("FAIL oflow_depth got %0d want 2", depth2); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem2[3] !== 16'd0) $display("FAIL oflow_nowrite got %0d want 0", mem2[3]); else n_pass++;
    n_checks++; if (tos2 !== 16'd22) $display("FAIL oflow_tos got %0d want 22", tos2); else n_pass++;
    err_clear2 = 1'b1;
    @(negedge clk);
    err_clear2 = 1'b0;
    n_checks++; if (ready2 !== 1'b1) $display("FAIL oflow_clear got %b want 1", ready2); else n_pass++;
`else
    issue2(OP_PUSH, 16'd33, 1'b1, low);
    n_checks++; if (low !== 2) $display("FAIL nolimit_ready_low got %0d want 2", low); else n_pass++;
    n_checks++; if (depth2 !== 16'd3) $display("FAIL nolimit_depth got %0d want 3", depth2); else n_pass++;
    n_checks++; if (tos2 !== 16'd33) $display("FAIL nolimit_tos got %0d want 33", tos2); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_write;
    apply_reset();
    @(negedge clk);
    op_valid = 1'b1; op = OP_PUSH; op_data = 16'd55;
    @(negedge clk);
    op_valid = 1'b0; op = OP_NOP;
    n_checks++; if (mem_wea !== 1'b1) $display("FAIL midrst_in_write got %b want 1", mem_wea); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_wea !== 1'b0) $display("FAIL midrst_wea got %b want 0", mem_wea); else n_pass++;
    n_checks++; if (mem_addr !== 16'd0) $display("FAIL midrst_sp got %0d want 0", mem_addr); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (depth !== 16'd0) $display("FAIL midrst_depth got %0d want 0", depth); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // random legal traffic against a queue model of the stack contents
  task automatic test_random;
    logic [15:0] stk[$];
    logic [15:0] v, exp_tos, exp_nos;
    logic [1:0]  o;
    int low, wc, exp_low, exp_wc;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      o = 2'($urandom_range(0, 3));
      v = 16'($urandom);
      if (stk.size() == 0 && (o == OP_POP || o == OP_POKE)) o = OP_PUSH;
      if (stk.size() >= 30 && o == OP_PUSH) o = OP_POP;
      issue(o, v, 1'b1, low, wc);
      case (o)
        OP_PUSH: begin stk.push_back(v); exp_low = 2; exp_wc = 1; end
        OP_POKE: begin stk[stk.size() - 1] = v; exp_low = 2; exp_wc = 1; end
        OP_POP:  begin void'(stk.pop_back()); exp_low = 1; exp_wc = 0; end
        default: begin exp_low = 0; exp_wc = 0; end
      endcase
      exp_tos = (stk.size() >= 1) ? stk[stk.size() - 1] : 16'h0000;
      exp_nos = (stk.size() >= 2) ? stk[stk.size() - 2] : 16'h0000;
      n_checks++; if (low !== exp_low) $display("FAIL rnd%0d_ready_low got %0d want %0d", i, low, exp_low); else n_pass++;
      n_checks++; if (wc !== exp_wc) $display("FAIL rnd%0d_wea got %0d want %0d", i, wc, exp_wc); else n_pass++;
      n_checks++; if (depth !== 16'(stk.size())) $display("FAIL rnd%0d_depth got %0d want %0d", i, depth, stk.size()); else n_pass++;
      n_checks++; if (tos !== exp_tos) $display("FAIL rnd%0d_tos got %h want %h", i, tos, exp_tos); else n_pass++;
      n_checks++; if (nos !== exp_nos) $display("FAIL rnd%0d_nos got %h want %h", i, nos, exp_nos); else n_pass++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_push();
    test_pop();
    test_poke();
    test_clear_idle();
    test_underflow();
    test_overflow();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_mem_ctrl.md
# stack_mem_ctrl

Stack-pointer controller that drives the 14-bit-addressed, 16-bit data memory from the requester side. It turns PUSH, POP and POKE requests into `addr`/`din`/`wea` sequences. It tracks the stack pointer and returns top-of-stack and next-on-stack from the memory's `douta`/`doutb` once they are valid. It sits between the core's execute stage and the data memory, and raises an exception on stack overflow, stack underflow or an out-of-range address.

## Interface
Parameters:
- `STACK_BASE`, 16'h0000: empty-stack pointer value. This slot is never written.
- `STACK_LIMIT`, 16'h3FFF: highest pushable address.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  request strobe.
- `op`  in  2  operation: 0 NOP, 1 PUSH, 2 POP, 3 POKE (replace top).
- `op_data`  in  16  data for PUSH/POKE.
- `err_clear`  in  1  leave FAULT.
- `ready`  out  1  idle; able to accept a request; `tos`/`nos` valid.
- `tos`  out  16  top of stack (passthrough of `mem_douta`).
- `nos`  out  16  next on stack (passthrough of `mem_doutb`).
- `depth`  out  16  `sp - STACK_BASE`.
- `err_code`  out  2  0 none, 1 overflow, 2 underflow, 3 address range.
- `mem_addr`  out  16  to memory `addr`.
- `mem_din`  out  16  to memory `din`.
- `mem_wea`  out  1  to memory `wea`.
- `mem_douta`  in  16  memory word at `mem_addr`.
- `mem_doutb`  in  16  memory word at `mem_addr - 1`.

## Operation
- States: IDLE, WRITE, SETTLE, FAULT.
- A request is accepted on a rising edge where `ready && op_valid`. There is no queue; a request presented while `ready` is low is ignored and must be held by the requester.
- IDLE: `mem_addr = sp`, `mem_wea = 0`, `ready = 1`.
- PUSH: `sp <= sp + 1`, go to WRITE. WRITE drives `mem_addr = sp`, `mem_din = op_data`, `mem_wea = 1`, then goes to SETTLE.
- POKE: `sp` is unchanged. Go to WRITE, which writes `op_data` at `sp`.
- POP: `sp <= sp - 1`, go to SETTLE.
- NOP: no state change.
- SETTLE: `mem_wea = 0`, `mem_addr = sp`. Next state is IDLE.
- Checks are made on the accept edge against the new pointer:
  - PUSH with `sp == STACK_LIMIT` gives error 1.
  - POP with `sp == STACK_BASE` gives error 2.
  - POKE with `sp == STACK_BASE` gives error 2.
  - A new address with bits [15:14] != 0 gives error 3. Error 1 has priority over error 3.
- On error: the operation is discarded, `sp` is unchanged, no write occurs, and the state goes to FAULT.
- FAULT is sticky: `ready = 0` and `err_code` is held. `err_clear` returns the block to IDLE with `err_code = 0`.
- `err_clear` outside FAULT has no effect. Clear takes effect in the same cycle as any `op_valid`, and that op is not accepted.

## Timing
- Reset values: state IDLE, `sp = STACK_BASE`, `mem_addr = STACK_BASE`, `mem_din = 0`, `mem_wea = 0`, `ready = 1`, `depth = 0`, `err_code = 0`.
- PUSH/POKE: `ready` is low for 2 cycles after the accept edge (WRITE, then SETTLE). The memory commits at the end of WRITE, and `tos` shows the new value when `ready` returns.
- POP: `ready` is low for 1 cycle (SETTLE).
- Error: FAULT is entered on the edge after accept. `err_code` is valid from then on.
- Reset mid-operation: asynchronous. `mem_wea` falls immediately, and a WRITE in progress is lost.
- `depth` updates on the accept edge.
- All outputs are registered except `tos`/`nos`, which pass straight through.

## Configuration
- `STACK_CTRL_BOUNDS_CHECK_EN` defined: all checks described above are active.
- `STACK_CTRL_BOUNDS_CHECK_EN` undefined: no checks. `sp` wraps modulo 2^16, `err_code` is tied to 0, FAULT is unreachable, and `err_clear` is ignored.

## Structure
- Package `stack_ctrl_pkg`: op encodings, err encodings, state enum, `ADDR_RANGE_MASK = 16'hC000`.
- One combinational sub-module, `stack_bounds_check`: inputs `sp`, `op`, parameters; outputs next pointer and `err_code`.

## Test plan
- Reset, then PUSH 100 → `ready` low 2 cycles; then `mem_addr = 1`, `tos = 100`, `nos = 0`, `depth = 1`.
- PUSH 100, PUSH 1000, POP → `tos = 100`, `depth = 1`; POP `ready` low exactly 1 cycle.
- PUSH 100, POKE 10000 → `tos = 10000`, `nos = 0`, `depth = 1`; `mem_wea` high exactly 1 cycle.
- POP from empty → `err_code = 2`, `ready = 0`, `sp = 0`; `err_clear` → `ready = 1`, `err_code = 0`.
- `STACK_LIMIT = 2`, three PUSHes → third gives `err_code = 1` and no write; `depth = 2`.
- Assert `reset` during WRITE of a PUSH → `mem_wea` is 0 within the same cycle, `sp = 0`, `ready = 1`.
